bp_nonsynth_mem_responder: RTL and testbench
============================================

Name: bp_nonsynth_mem_responder

Overview:
- Non-synthesizable memory-side responder for the CCE-to-memory interface.
- Accepts bp_cce_mem_msg_s commands from a CCE, holds a small block-addressed backing store, and returns one bp_cce_mem_msg_s response per command after a programmable latency.
- Used in testbenches in place of DRAM/L2; it is the memory end of the interface whose CCE end issues the commands.

Parameters:
- bp_params_p, e_bp_inv_cfg: processor config. Supplies paddr_width_p, cce_block_width_p (512), lce_id_width_p, lce_max_assoc_p.
- mem_els_p, 64: number of cache blocks in the backing store. Power of two, at least 2.
- latency_p, 4: cycles from command acceptance to response valid. Minimum 1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- mem_cmd_i  in  cce_mem_msg_width_lp  command message (header plus data)
- mem_cmd_v_i  in  1  command valid
- mem_cmd_ready_o  out  1  responder can accept a command
- mem_resp_o  out  cce_mem_msg_width_lp  response message
- mem_resp_v_o  out  1  response valid
- mem_resp_yumi_i  in  1  consumer takes the response this cycle (asserted only while mem_resp_v_o=1)

Behaviour:
- Reset (async assert, sampled release):
  - state=e_ready
  - mem_cmd_ready_o=0 while reset_i=1, 1 in the first cycle after release
  - mem_resp_v_o=0, mem_resp_o=0, latency counter=0
  - all backing-store blocks=0
  - Reset mid-operation drops any in-flight command; no response is issued for it.
- One outstanding command. FSM states:
  - e_ready: mem_cmd_ready_o=1. Accept on mem_cmd_v_i & mem_cmd_ready_o. Latch the header, perform the store update (writes) or read capture in the same edge, load counter=latency_p-1, go to e_wait. mem_cmd_ready_o depends only on state, never combinationally on mem_cmd_v_i.
  - e_wait: ready=0. Counter decrements each cycle. When counter==0, go to e_resp. With latency_p=1, go e_ready -> e_resp directly, so the response is valid the cycle after acceptance.
  - e_resp: mem_resp_v_o=1 with a stable payload until mem_resp_yumi_i. On yumi go to e_ready; ready=1 the following cycle (no same-cycle accept).
- Latency: the response is valid exactly latency_p cycles after the acceptance edge. Back-to-back throughput is 1 command per latency_p+1 cycles, plus any consumer stall.
- Indexing:
  - block index = addr[lg(cce_block_width_p/8) +: lg(mem_els_p)]
  - Upper address bits are ignored, so addresses alias modulo mem_els_p blocks.
  - byte offset = addr[lg(cce_block_width_p/8)-1:0]
- Command types:
  - e_cce_mem_rd, e_cce_mem_wr (cached block read): response data = full block. Address is block-aligned by the low offset bits being ignored.
  - e_cce_mem_wb: the whole block is written with data. Response data=0.
  - e_cce_mem_uc_rd: bytes=2^size (sizes 1, 2, 4, 8 bytes). Offset is aligned down to size. Response data low bytes*8 bits = stored bytes; upper bits=0.
  - e_cce_mem_uc_wr: writes the low bytes*8 bits of data at the aligned offset; other bytes are untouched. Response data=0.
- Response header: msg_type, addr, size and payload are echoed bit-exact from the command, including unaligned addr.
- Read data is captured at acceptance. A later write cannot alter an in-flight response; with one outstanding command this cannot occur anyway.
- Error checks (simulation only; the response is still issued):
  - uc size >8 bytes -> $error, treated as 8 bytes
  - misaligned uc addr -> $warning
  - mem_resp_yumi_i while !mem_resp_v_o -> $error
  - unknown msg_type -> $fatal

Test Plan:
- Reset then idle: reset_i pulse mid-cycle -> outputs 0 immediately. ready=1 the first cycle after release. mem_resp_v_o stays 0 with no commands.
- wb then rd: wb addr=0x8000_0040, data=512'hA5.., then rd addr=0x8000_0040 -> rd response data=512'hA5.. exactly 4 cycles after acceptance, header echoed, payload unchanged.
- uc_wr 4 bytes: addr=0x8000_0044, data=32'hDEADBEEF; then uc_rd size=8 bytes, addr=0x8000_0040 -> data=64'hDEADBEEF_00000000, upper bits zero.
- Aliasing: mem_els_p=64, wb to block 0, rd at addr+64*64 bytes -> same data returned.
- Backpressure: hold yumi=0 for 10 cycles -> mem_resp_v_o=1 with stable data, ready=0 throughout; yumi=1 -> v=0 next cycle, ready=1.
- Reset mid-wait: accept rd, assert reset_i at counter=2 -> no response ever appears; store is cleared, so a subsequent rd returns 0.

Source files
------------

// File: rtl/bp_nonsynth_mem_responder.sv
// Memory-side responder for the CCE-to-memory interface, for use in benches
// in place of DRAM/L2. It accepts one command at a time, keeps a small
// block-addressed backing store, and returns one response latency_p cycles
// after acceptance.
//
// Message layout, MSB to LSB:
//   data[cce_block_width_p] | payload | size[3] | addr[paddr_width_p] | msg_type[4]
//   payload = {lce_id, way_id, state[3]}; it is echoed and never interpreted.
//   size    = log2(bytes): 0=1B, 1=2B, 2=4B, 3=8B ... 6=64B
//   Block data is little-endian: byte n of a block sits at data[8n +: 8].
module bp_nonsynth_mem_responder #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_max_assoc_p   = 8,
    parameter int mem_els_p         = 64,
    parameter int latency_p         = 4,
    localparam int way_id_width_lp     = $clog2(lce_max_assoc_p),
    localparam int payload_width_lp    = lce_id_width_p + way_id_width_lp + 3,
    localparam int hdr_width_lp        = payload_width_lp + 3 + paddr_width_p + 4,
    localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i
);

    localparam int bytes_lp = cce_block_width_p / 8;
    localparam int off_w_lp = $clog2(bytes_lp);
    localparam int idx_w_lp = $clog2(mem_els_p);
    localparam int cnt_w_lp = (latency_p > 1) ? $clog2(latency_p) : 1;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_wb    = 4'd4
    } msg_type_e;

    typedef struct packed {
        logic [payload_width_lp-1:0] payload;
        logic [2:0]                  size;
        logic [paddr_width_p-1:0]    addr;
        logic [3:0]                  msg_type;
    } hdr_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        hdr_s                         hdr;
    } msg_s;

    typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

    state_e                      state;
    logic [cnt_w_lp-1:0]         cnt;
    msg_s                        resp_r;
    logic [bytes_lp-1:0][7:0]    mem_r [mem_els_p];

    msg_s                        cmd;
    logic [idx_w_lp-1:0]         idx;
    logic [off_w_lp-1:0]         off;
    logic [off_w_lp-1:0]         lo_mask;
    logic [off_w_lp-1:0]         off_al;
    logic [1:0]                  lg_sz;
    logic [3:0]                  nbytes;
    logic [bytes_lp-1:0][7:0]    blk_rd;
    logic [bytes_lp-1:0][7:0]    uc_blk;
    logic [7:0][7:0]             uc_rdata;

    assign cmd = msg_s'(mem_cmd_i);

    // Upper address bits fall off here, so addresses alias modulo mem_els_p blocks.
    assign idx = cmd.hdr.addr[off_w_lp +: idx_w_lp];
    assign off = cmd.hdr.addr[off_w_lp-1:0];

    // Uncached accesses wider than 8 bytes are clamped to 8 bytes.
    assign lg_sz   = (cmd.hdr.size > 3'd3) ? 2'd3 : cmd.hdr.size[1:0];
    assign nbytes  = 4'd1 << lg_sz;
    assign lo_mask = off_w_lp'((8'd1 << lg_sz) - 8'd1);
    assign off_al  = off & ~lo_mask;

    // Block read plus the uncached byte-lane extract/merge at the aligned offset.
    always_comb begin
        blk_rd   = mem_r[idx];
        uc_blk   = blk_rd;
        uc_rdata = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < nbytes) begin
                uc_rdata[b]                       = blk_rd[off_al + off_w_lp'(b)];
                uc_blk[off_al + off_w_lp'(b)]     = cmd.data[8*b +: 8];
            end
        end
    end

    // Ready is a pure decode of state; it is held low while reset is asserted.
    assign mem_cmd_ready_o = (state == e_ready) && !reset_i;
    assign mem_resp_v_o    = (state == e_resp);
    assign mem_resp_o      = resp_r;

    // Command FSM: store update and read capture happen on the acceptance edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= e_ready;
            cnt    <= '0;
            resp_r <= '0;
            for (int i = 0; i < mem_els_p; i++) mem_r[i] <= '0;
        end else begin
            case (state)
                e_ready: begin
                    if (mem_cmd_v_i) begin
                        resp_r.hdr  <= cmd.hdr;
                        resp_r.data <= '0;
                        case (cmd.hdr.msg_type)
                            e_cce_mem_rd,
                            e_cce_mem_wr:    resp_r.data <= blk_rd;
                            e_cce_mem_uc_rd: resp_r.data <= cce_block_width_p'(uc_rdata);
                            e_cce_mem_uc_wr: mem_r[idx]  <= uc_blk;
                            e_cce_mem_wb:    mem_r[idx]  <= cmd.data;
                            default: ;
                        endcase
                        cnt   <= cnt_w_lp'(latency_p - 1);
                        state <= (latency_p == 1) ? e_resp : e_wait;
                    end
                end
                e_wait: begin
                    if (cnt == '0) state <= e_resp;
                    else           cnt   <= cnt - 1'b1;
                end
                e_resp: begin
                    if (mem_resp_yumi_i) state <= e_ready;
                end
                default: state <= e_ready;
            endcase
        end
    end

    // Protocol and command sanity checks; the response is still issued.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state == e_ready && mem_cmd_v_i) begin
                if (cmd.hdr.msg_type > e_cce_mem_wb)
                    $fatal(1, "mem_responder: unknown msg_type %0d", cmd.hdr.msg_type);
                if (cmd.hdr.msg_type == e_cce_mem_uc_rd || cmd.hdr.msg_type == e_cce_mem_uc_wr) begin
                    if (cmd.hdr.size > 3'd3)
                        $error("mem_responder: uc size %0d exceeds 8 bytes", cmd.hdr.size);
                    if ((off & lo_mask) != '0)
                        $warning("mem_responder: misaligned uc addr %h", cmd.hdr.addr);
                end
            end
            if (mem_resp_yumi_i && !mem_resp_v_o)
                $error("mem_responder: yumi without valid response");
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_mem_responder.sv
// Directed bench for bp_nonsynth_mem_responder with hand-computed expectations.
module tb_bp_nonsynth_mem_responder;

    localparam int MSG_W = 569;   // 512 data + 10 payload + 3 size + 40 addr + 4 type
    localparam int HDR_W = 57;
    localparam int LAT   = 4;

    localparam logic [3:0] T_RD = 4'd0, T_UC_RD = 4'd2, T_UC_WR = 4'd3, T_WB = 4'd4;
    localparam logic [9:0] PAYLOAD = 10'h2A5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [MSG_W-1:0] mem_cmd_i = '0;
    logic             mem_cmd_v_i = 1'b0;
    logic             mem_cmd_ready_o;
    logic [MSG_W-1:0] mem_resp_o;
    logic             mem_resp_v_o;
    logic             mem_resp_yumi_i = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    bp_nonsynth_mem_responder dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_ready_o (mem_cmd_ready_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_yumi_i (mem_resp_yumi_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                            input logic [2:0] sz, input logic [511:0] d);
        return {d, PAYLOAD, sz, a, t};
    endfunction

    // Present a command and hold valid until the accepting edge; returns #1 after it.
    task automatic send(input logic [MSG_W-1:0] m);
        int n = 0;
        mem_cmd_i   = m;
        mem_cmd_v_i = 1'b1;
        while (!mem_cmd_ready_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        mem_cmd_v_i = 1'b0;
    endtask

    // Cycles from the acceptance edge until a response is valid (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!mem_resp_v_o && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic take();
        mem_resp_yumi_i = 1'b1;
        @(posedge clk); #1;
        mem_resp_yumi_i = 1'b0;
    endtask

    logic [MSG_W-1:0] m;
    logic [511:0]     a5 = {64{8'hA5}};
    logic [511:0]     pat = {16{32'h1234_5678}};
    int lat;
    int seen_v;

    initial begin
        // Reset pulse mid-cycle: outputs drop immediately.
        #12 rst = 1'b1;
        #1;
        chk("rst_ready", mem_cmd_ready_o, 0);
        chk("rst_v", mem_resp_v_o, 0);
        chk("rst_resp", mem_resp_o, 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("rel_ready", mem_cmd_ready_o, 1);
        seen_v = 0;
        repeat (5) begin @(posedge clk); #1; seen_v += int'(mem_resp_v_o); end
        chk("idle_no_v", seen_v, 0);

        // Writeback then read of the same block.
        m = mk(T_WB, 40'h80_0000_0040, 3'd6, a5);
        send(m);
        wait_resp(lat);
        chk("wb_lat", lat, LAT);
        chk("wb_hdr", mem_resp_o[HDR_W-1:0], m[HDR_W-1:0]);
        chk("wb_data", mem_resp_o[MSG_W-1:HDR_W], 0);
        take();
        chk("wb_v_drop", mem_resp_v_o, 0);
        chk("wb_ready", mem_cmd_ready_o, 1);

        m = mk(T_RD, 40'h80_0000_0040, 3'd6, '0);
        send(m);
        wait_resp(lat);
        chk("rd_lat", lat, LAT);
        chk("rd_hdr", mem_resp_o[HDR_W-1:0], m[HDR_W-1:0]);
        chk("rd_data", mem_resp_o[MSG_W-1:HDR_W], a5);

        // Backpressure: hold the response for 10 cycles.
        seen_v = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_resp_v_o && !mem_cmd_ready_o && mem_resp_o[MSG_W-1:HDR_W] == a5) seen_v++;
        end
        chk("bp_stable", seen_v, 10);
        take();
        chk("bp_v_drop", mem_resp_v_o, 0);
        chk("bp_ready", mem_cmd_ready_o, 1);

        // Aliasing: block 0 and 64 blocks above it share storage.
        m = mk(T_WB, 40'h80_0000_0000, 3'd6, pat);
        send(m); wait_resp(lat); take();
        m = mk(T_RD, 40'h80_0000_1000 + 40'h5, 3'd6, '0);   // unaligned, offset ignored
        send(m);
        wait_resp(lat);
        chk("alias_data", mem_resp_o[MSG_W-1:HDR_W], pat);
        chk("alias_hdr", mem_resp_o[HDR_W-1:0], m[HDR_W-1:0]);
        take();

        // Reset while waiting: no response, store cleared.
        m = mk(T_RD, 40'h80_0000_0040, 3'd6, '0);
        send(m);                 // counter now 3
        @(posedge clk); #2;      // counter now 2
        rst = 1'b1;
        #1;
        chk("mid_rst_v", mem_resp_v_o, 0);
        chk("mid_rst_ready", mem_cmd_ready_o, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        seen_v = 0;
        repeat (10) begin @(posedge clk); #1; seen_v += int'(mem_resp_v_o); end
        chk("mid_rst_no_resp", seen_v, 0);
        send(m);
        wait_resp(lat);
        chk("cleared_lat", lat, LAT);
        chk("cleared_data", mem_resp_o[MSG_W-1:HDR_W], 0);
        take();

        // Uncached 4-byte write then 8-byte read of the surrounding bytes.
        m = mk(T_UC_WR, 40'h80_0000_0044, 3'd2, 512'hDEADBEEF);
        send(m);
        wait_resp(lat);
        chk("ucwr_data", mem_resp_o[MSG_W-1:HDR_W], 0);
        chk("ucwr_hdr", mem_resp_o[HDR_W-1:0], m[HDR_W-1:0]);
        take();
        m = mk(T_UC_RD, 40'h80_0000_0040, 3'd3, '0);
        send(m);
        wait_resp(lat);
        chk("ucrd_lat", lat, LAT);
        chk("ucrd_data", mem_resp_o[MSG_W-1:HDR_W], 512'hDEADBEEF_00000000);
        take();

        // 2-byte uncached read from the middle of the written word.
        m = mk(T_UC_RD, 40'h80_0000_0046, 3'd1, '0);
        send(m);
        wait_resp(lat);
        chk("ucrd2_data", mem_resp_o[MSG_W-1:HDR_W], 512'hDEAD);
        take();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
